risc_sequencer: RTL
===================

Name: risc_sequencer

Overview:
- Control sequencer for the 8-bit accumulator CPU; sits directly upstream of the ALU.
- Steps every instruction through a fixed 8-phase fetch/execute cycle.
- Decodes the 3-bit opcode held in the instruction register and the ALU's accumulator-zero flag.
- Drives the memory, PC, IR, accumulator and ALU enables that move operands into and results out of the ALU.

Parameters:
- HALT_STICKY, 1: 1 = HLT freezes the sequencer in HALTED until reset; 0 = halt pulses for one phase and sequencing continues.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  3  instruction-register opcode: HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111
- zero  input  1  ALU accumulator-zero flag (a_is_zero)
- sel  output  1  1 = memory address from PC, 0 = from IR operand field
- rd  output  1  memory read enable
- ld_ir  output  1  instruction register load
- inc_pc  output  1  program counter increment
- ld_pc  output  1  program counter load (jump)
- ld_ac  output  1  accumulator load from alu_out
- wr  output  1  memory write strobe
- data_e  output  1  accumulator drive onto data bus
- halt  output  1  processor halted
- phase  output  3  current phase number, debug/trace

Behaviour:
- Reset and state register:
  - Clock and reset: one clock; reset is asynchronous and active-high.
  - State is a registered 3-bit phase, plus a HALTED flag when HALT_STICKY=1.
  - rst asserted, at any time including mid-instruction, forces phase=0 (INST_ADDR) and clears HALTED immediately, without waiting for a clock edge.
- Phase sequence:
  - Order: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
  - Each advances unconditionally by one per clock; 7 wraps to 0.
  - Every instruction takes exactly 8 clocks.
- Decode helpers:
  - ALUOP = opcode in {ADD, AND, XOR, LDA}.
  - opcode and zero are sampled combinationally; the IR is stable from phase 3 on.
- Outputs are a combinational decode of phase, opcode and zero (Moore in phase). Any output not listed for a phase is 0.
  - Phase 0: sel=1.
  - Phase 1: sel=1, rd=1.
  - Phase 2: sel=1, rd=1, ld_ir=1.
  - Phase 3: sel=1, rd=1, ld_ir=1.
  - Phase 4: inc_pc=1; halt=1 if opcode=HLT.
  - Phase 5: rd=ALUOP.
  - Phase 6: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - Phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; inc_pc=JMP; wr=STO; data_e=STO.
- Reset output values: phase 0 decode, i.e. sel=1, phase=0, all other outputs 0.
- HLT handling:
  - HALT_STICKY=1: on the clock edge leaving phase 4 with opcode=HLT, enter HALTED.
    - phase holds at 4.
    - halt=1; every other output is 0.
    - Only rst exits HALTED.
  - HALT_STICKY=0: halt is high for phase 4 only, then sequencing continues normally.
- SKZ: the extra inc_pc in phase 6 depends on zero as sampled during phase 6 only; a change of zero in other phases is ignored.
- JMP: ld_pc and inc_pc are both high in phase 7; the PC must give ld_pc priority. The sequencer does not arbitrate.
- wr and data_e: wr is never high without data_e in the same cycle; data_e alone leads wr by one phase for bus setup.
- Unknown/X opcode: decoded as non-ALUOP, non-branch, so no ld_ac, ld_pc or wr; no assertion is raised.

Test Plan:
- Reset and fetch: assert rst for 2 clocks mid-phase-5, release with opcode=ADD. Phase reads 0 immediately on rst; after release phases 0..7 follow; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; inc_pc only in phase 4.
- Store: opcode=STO for one instruction. data_e=1 in phases 6-7; wr=1 in phase 7 only; rd=0 and ld_ac=0 in phases 5-7.
- Skip on zero: opcode=SKZ with zero=1 in phase 6, then zero=0 on the next instruction. inc_pc=1 in phases 4 and 6 on the first instruction; phase 4 only on the second.
- Jump: opcode=JMP. ld_pc=1 in phases 6 and 7; inc_pc=1 in phases 4 and 7; wr=0 throughout.
- Halt: HALT_STICKY=1, opcode=HLT. halt rises in phase 4 and stays 1 with phase=4 for 20+ clocks; all other outputs 0; after rst pulse, phase=0, halt=0. With HALT_STICKY=0, halt is high for exactly 1 clock and phase reaches 5.
- Wrap: 3 back-to-back LDA instructions. ld_ir pulses in phases 2-3 of each; 24 clocks total; phase steps 7->0 with no bubble.

Source files
------------

// File: rtl/risc_sequencer.sv
// risc_sequencer -- control sequencer for the 8-bit accumulator CPU.
// Steps every instruction through a fixed 8-phase fetch/execute cycle and
// decodes opcode/zero into the memory, PC, IR, accumulator and ALU enables.
//
// Ports:
//   clk     in   system clock, all state on rising edge
//   rst     in   asynchronous active-high reset
//   opcode  in   [2:0] IR opcode (HLT SKZ ADD AND XOR LDA STO JMP)
//   zero    in   ALU accumulator-zero flag
//   sel     out  memory address from PC (1) or IR operand (0)
//   rd      out  memory read enable
//   ld_ir   out  instruction register load
//   inc_pc  out  program counter increment
//   ld_pc   out  program counter load (PC gives ld_pc priority over inc_pc)
//   ld_ac   out  accumulator load from alu_out
//   wr      out  memory write strobe
//   data_e  out  accumulator drive onto data bus
//   halt    out  processor halted
//   phase   out  [2:0] current phase number
module risc_sequencer #(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OPC_HLT = 3'b000;
  localparam logic [2:0] OPC_SKZ = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_AND = 3'b011;
  localparam logic [2:0] OPC_XOR = 3'b100;
  localparam logic [2:0] OPC_LDA = 3'b101;
  localparam logic [2:0] OPC_STO = 3'b110;
  localparam logic [2:0] OPC_JMP = 3'b111;

  phase_t r_phase;
  phase_t w_phase_nxt;
  logic   r_halted;
  logic   w_halted_nxt;

  logic   w_is_hlt;
  logic   w_is_skz;
  logic   w_is_sto;
  logic   w_is_jmp;
  logic   w_aluop;

  // Opcode decode via case so an X/Z opcode falls into the default arm and
  // is treated as a harmless non-ALU, non-branch instruction.
  always_comb begin
    w_is_hlt = 1'b0;
    w_is_skz = 1'b0;
    w_is_sto = 1'b0;
    w_is_jmp = 1'b0;
    w_aluop  = 1'b0;
    case (opcode)
      OPC_HLT: w_is_hlt = 1'b1;
      OPC_SKZ: w_is_skz = 1'b1;
      OPC_ADD,
      OPC_AND,
      OPC_XOR,
      OPC_LDA: w_aluop  = 1'b1;
      OPC_STO: w_is_sto = 1'b1;
      OPC_JMP: w_is_jmp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  always_comb begin
    w_phase_nxt  = phase_t'(r_phase + 3'd1);
    w_halted_nxt = r_halted;
    if (HALT_STICKY) begin
      if (r_halted) begin
        w_phase_nxt = r_phase;
      end else if (r_phase == OP_ADDR && w_is_hlt) begin
        // Freeze at OP_ADDR; only rst leaves HALTED.
        w_phase_nxt  = OP_ADDR;
        w_halted_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (r_halted) begin
      halt = 1'b1;
    end else begin
      case (r_phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = w_is_hlt;
        end
        OP_FETCH: begin
          rd = w_aluop;
        end
        ALU_OP: begin
          rd     = w_aluop;
          inc_pc = w_is_skz & zero;
          ld_pc  = w_is_jmp;
          data_e = w_is_sto;
        end
        STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = w_is_jmp;
          inc_pc = w_is_jmp;
          wr     = w_is_sto;
          data_e = w_is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase = r_phase;

endmodule
